// File: rtl/bit_index_encoder.sv
// rtl/bit_index_encoder.sv - streaming multi-hot to bit-index encoder (optional BIT_INDEX_ENC_MSB_FIRST_EN: descending order)
module bit_index_encoder #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_zero
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   pend_q;
    logic [N-1:0]   pend_d;
    logic [N-1:0]   rem;
    logic           valid_d;
    logic [W-1:0]   idx_d;
    logic           last_d;
    logic           zero_d;

    // Index of the lowest set bit; 0 for an empty vector.
    function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[W-1:0];
            end
        end
        return idx;
    endfunction

    // Index of the highest set bit; 0 for an empty vector.
    function automatic logic [W-1:0] highest_idx(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = i[W-1:0];
            end
        end
        return idx;
    endfunction

    // Emission order is chosen here; everything else is order-agnostic.
    function automatic logic [W-1:0] pick_idx(input logic [N-1:0] v);
`ifdef BIT_INDEX_ENC_MSB_FIRST_EN
        return highest_idx(v);
`else
        return lowest_idx(v);
`endif
    endfunction

    // True when at most one bit is set: the picked bit is then the final beat.
    function automatic logic at_most_one(input logic [N-1:0] v);
        return (v & (v - ONE)) == '0;
    endfunction

    assign in_ready = (state_q == IDLE);

    // State, pending mask and registered beat outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            out_valid <= valid_d;
            out_idx   <= idx_d;
            out_last  <= last_d;
            out_zero  <= zero_d;
        end
    end

    // Next state: accept a vector in IDLE, then walk its set bits one beat per handshake.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        valid_d = out_valid;
        idx_d   = out_idx;
        last_d  = out_last;
        zero_d  = out_zero;
        rem     = pend_q & ~(ONE << out_idx);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = EMIT;
                    pend_d  = in_vec;
                    valid_d = 1'b1;
                    idx_d   = pick_idx(in_vec);
                    last_d  = at_most_one(in_vec);
                    zero_d  = (in_vec == '0);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_last) begin
                        // Final beat taken; no lookahead accept on this edge.
                        state_d = IDLE;
                        pend_d  = '0;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        last_d  = 1'b0;
                        zero_d  = 1'b0;
                    end else begin
                        pend_d  = rem;
                        idx_d   = pick_idx(rem);
                        last_d  = at_most_one(rem);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_index_encoder.sv
// tb/tb_bit_index_encoder.sv - table-driven bench for bit_index_encoder (honours BIT_INDEX_ENC_MSB_FIRST_EN)
module tb_bit_index_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_idx;
    logic       out_last;
    logic       out_zero;

    int n_chk;
    int n_fail;

    bit_index_encoder #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected set-bit indices listed ascending; the MSB-first build walks them backwards.
    typedef struct packed {
        logic [3:0]      vec;
        logic [2:0]      n;
        logic [3:0][1:0] idxs;
        logic            zero;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] nth(input vec_t v, input int k);
`ifdef BIT_INDEX_ENC_MSB_FIRST_EN
        return v.idxs[int'(v.n) - 1 - k];
`else
        return v.idxs[k];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector, then check every beat with out_ready held high.
    task automatic run_vec(input vec_t v);
        chk("pre_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_vec   = v.vec;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_vec   = 4'hf;
        for (int k = 0; k < int'(v.n); k++) begin
            chk($sformatf("v%h_b%0d_valid", v.vec, k), out_valid, 1'b1);
            chk($sformatf("v%h_b%0d_idx", v.vec, k), out_idx, nth(v, k));
            chk($sformatf("v%h_b%0d_last", v.vec, k), out_last, (k == int'(v.n) - 1));
            chk($sformatf("v%h_b%0d_zero", v.vec, k), out_zero, v.zero);
            chk($sformatf("v%h_b%0d_in_ready", v.vec, k), in_ready, 1'b0);
            tick();
        end
        chk($sformatf("v%h_done_valid", v.vec), out_valid, 1'b0);
        chk($sformatf("v%h_done_in_ready", v.vec), in_ready, 1'b1);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        tbl[0] = '{vec: 4'b0100, n: 3'd1, idxs: {2'd0, 2'd0, 2'd0, 2'd2}, zero: 1'b0};
        tbl[1] = '{vec: 4'b1011, n: 3'd3, idxs: {2'd0, 2'd3, 2'd1, 2'd0}, zero: 1'b0};
        tbl[2] = '{vec: 4'b0000, n: 3'd1, idxs: {2'd0, 2'd0, 2'd0, 2'd0}, zero: 1'b1};
        tbl[3] = '{vec: 4'b1000, n: 3'd1, idxs: {2'd0, 2'd0, 2'd0, 2'd3}, zero: 1'b0};
        tbl[4] = '{vec: 4'b1111, n: 3'd4, idxs: {2'd3, 2'd2, 2'd1, 2'd0}, zero: 1'b0};
        tbl[5] = '{vec: 4'b0001, n: 3'd1, idxs: {2'd0, 2'd0, 2'd0, 2'd0}, zero: 1'b0};
        tbl[6] = '{vec: 4'b1010, n: 3'd2, idxs: {2'd0, 2'd0, 2'd3, 2'd1}, zero: 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 4'h0;
        out_ready = 1'b0;
        tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_idx", out_idx, 2'd0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_zero", out_zero, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i]);
            tick();
        end

        // Backpressure: first beat held for 3 cycles while a new vector is offered and must be ignored.
        in_valid  = 1'b1;
        in_vec    = 4'b0110;
        out_ready = 1'b0;
        tick();
        in_vec = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            chk("bp_valid", out_valid, 1'b1);
`ifdef BIT_INDEX_ENC_MSB_FIRST_EN
            chk("bp_idx", out_idx, 2'd2);
`else
            chk("bp_idx", out_idx, 2'd1);
`endif
            chk("bp_last", out_last, 1'b0);
            chk("bp_in_ready", in_ready, 1'b0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef BIT_INDEX_ENC_MSB_FIRST_EN
        chk("bp_b0_idx", out_idx, 2'd2);
`else
        chk("bp_b0_idx", out_idx, 2'd1);
`endif
        tick();
        chk("bp_b1_valid", out_valid, 1'b1);
`ifdef BIT_INDEX_ENC_MSB_FIRST_EN
        chk("bp_b1_idx", out_idx, 2'd1);
`else
        chk("bp_b1_idx", out_idx, 2'd2);
`endif
        chk("bp_b1_last", out_last, 1'b1);
        tick();
        chk("bp_done_valid", out_valid, 1'b0);
        chk("bp_done_in_ready", in_ready, 1'b1);
        tick();

        // Asynchronous reset in the middle of a multi-beat vector.
        in_valid  = 1'b1;
        in_vec    = 4'b1011;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("mid_valid", out_valid, 1'b1);
        chk("mid_last", out_last, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_idx", out_idx, 2'd0);
        chk("mid_rst_last", out_last, 1'b0);
        chk("mid_rst_zero", out_zero, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_in_ready", in_ready, 1'b1);
        chk("mid_rel_valid", out_valid, 1'b0);

        // Pending beats from before the reset must not reappear.
        run_vec(tbl[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
